// File: rtl/cla_16bit.sv
// 16-bit two-level carry-lookahead adder.
// Four 4-bit lookahead groups feed one second-level lookahead unit.
// Optional output register: define CLA_16BIT_REG_OUT_EN to register sum/cout on the
// rising clk edge with an asynchronous active-low clear; otherwise the outputs are
// purely combinational and clk/rst are ignored.

module cla_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] p;
  logic [15:0] g;
  logic [16:0] c;
  logic [3:0]  grp_p;
  logic [3:0]  grp_g;
  logic [15:0] sum_d;
  logic        cout_d;

  // Per-bit propagate and generate
  always_comb begin
    p = in_a ^ in_b;
    g = in_a & in_b;
  end

  // Group propagate/generate from each 4-bit slice
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second-level lookahead: group carries straight from cin and group P/G
  always_comb begin
    c     = '0;
    c[0]  = cin;
    c[4]  = grp_g[0]
          | (grp_p[0] & cin);
    c[8]  = grp_g[1]
          | (grp_p[1] & grp_g[0])
          | (grp_p[1] & grp_p[0] & cin);
    c[12] = grp_g[2]
          | (grp_p[2] & grp_g[1])
          | (grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    c[16] = grp_g[3]
          | (grp_p[3] & grp_g[2])
          | (grp_p[3] & grp_p[2] & grp_g[1])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
          | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);
    // In-group carries, flattened from the group carry-in (no ripple inside a group)
    for (int k = 0; k < 4; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
    end
  end

  // Sum bits and carry-out
  always_comb begin
    sum_d  = p ^ c[15:0];
    cout_d = c[16];
  end

`ifdef CLA_16BIT_REG_OUT_EN
  logic [15:0] sum_q;
  logic        cout_q;

  // Output register; low rst clears immediately and holds until the next edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`else
  // clk and rst are kept on the interface but have no function in this build
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign sum  = sum_d;
  assign cout = cout_d;
`endif

endmodule

// File: tb/tb_cla_16bit.sv
// Self-checking bench for cla_16bit; covers both the combinational and the
// registered-output build (CLA_16BIT_REG_OUT_EN).

module tb_cla_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;

  int checks;
  int failures;

  cla_16bit u_dut (
    .clk  (clk),
    .rst  (rst),
    .in_a (in_a),
    .in_b (in_b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [16:0] got, input logic [16:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {cout,sum}=%05h expected %05h", tag, got, exp);
    end
  endtask

  // Drive one vector and wait until the result is visible at the outputs
  task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic ci);
    in_a = a;
    in_b = b;
    cin  = ci;
`ifdef CLA_16BIT_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] model;

    checks   = 0;
    failures = 0;

    vecs[0] = '{"zero",         16'h0000, 16'h0000, 1'b0, 17'h0_0000};
    vecs[1] = '{"full_chain",   16'hFFFF, 16'h0001, 1'b0, 17'h1_0000};
    vecs[2] = '{"group_bounds", 16'h00FF, 16'h0F01, 1'b0, 17'h0_1000};
    vecs[3] = '{"all_ones_ci",  16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF};
    vecs[4] = '{"ffff_ci",      16'hFFFF, 16'h0000, 1'b1, 17'h1_0000};
    vecs[5] = '{"no_carry",     16'h1234, 16'h4321, 1'b0, 17'h0_5555};
    vecs[6] = '{"msb_only",     16'h8000, 16'h8000, 1'b0, 17'h1_0000};
    vecs[7] = '{"alt_ci",       16'hAAAA, 16'h5555, 1'b1, 17'h1_0000};
    vecs[8] = '{"into_msb",     16'h7FFF, 16'h0000, 1'b1, 17'h0_8000};

    // Reset held low from time zero with nonzero inputs
    rst  = 1'b0;
    in_a = 16'h1234;
    in_b = 16'h0001;
    cin  = 1'b0;
    #2;
`ifdef CLA_16BIT_REG_OUT_EN
    check_eq("reset_clear", {cout, sum}, 17'h0_0000);
`else
    check_eq("reset_ignored", {cout, sum}, 17'h0_1235);
`endif
    #1 rst = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].ci);
      check_eq(vecs[i].tag, {cout, sum}, vecs[i].exp);
    end

    // Random vectors, each held 10 cycles, against an arithmetic reference
    for (int n = 0; n < 20; n++) begin
      ra = 16'($urandom_range(0, 65534));
      rb = 16'($urandom_range(0, 65534));
      rc = 1'($urandom_range(0, 1));
      in_a = ra;
      in_b = rb;
      cin  = rc;
      repeat (10) @(posedge clk);
      #1;
      model = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      check_eq($sformatf("rand%0d", n), {cout, sum}, model);
    end

`ifdef CLA_16BIT_REG_OUT_EN
    // Mid-operation async reset, then release between edges
    apply(16'h1234, 16'h0001, 1'b0);
    check_eq("settled_1235", {cout, sum}, 17'h0_1235);
    #2 rst = 1'b0;
    #1;
    check_eq("async_clear", {cout, sum}, 17'h0_0000);
    @(posedge clk);
    #1;
    check_eq("held_in_reset", {cout, sum}, 17'h0_0000);
    #2 rst = 1'b1;
    #1;
    check_eq("no_residual", {cout, sum}, 17'h0_0000);
    @(posedge clk);
    #1;
    check_eq("after_release", {cout, sum}, 17'h0_1235);
`else
    // Reset low mid-operation must not disturb combinational outputs
    apply(16'h1234, 16'h0001, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("rst_no_effect", {cout, sum}, 17'h0_1235);
    rst = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cla_16bit.md
CLA_16BIT -- requirements
Module: cla_16bit

Interface
REQ-001 Parameters: none; datapath width fixed at 16 bits.
REQ-002 clk  input  1  single clock; used only when CLA_16BIT_REG_OUT_EN is defined.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 in_a  input  16  addend A, unsigned.
REQ-005 in_b  input  16  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 sum  output  16  sum bits [15:0].
REQ-008 cout  output  1  carry-out (bit 16 of result).

Function
REQ-009 {cout,sum} SHALL equal in_a + in_b + cin, full 17-bit result, modulo nothing; no overflow flag.
REQ-010 Per-bit propagate p[i] = a[i]^b[i], generate g[i] = a[i]&b[i]; sum[i] = p[i]^c[i], with c[0] = cin.
REQ-011 Datapath SHALL be four 4-bit carry-lookahead groups (bits 3:0, 7:4, 11:8, 15:12); each group computes internal carries c[i+1..i+3] directly from p/g and group carry-in, with no ripple inside the group.
REQ-012 Each group SHALL output group propagate P = AND of its p and group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
REQ-013 A second-level lookahead unit SHALL compute c4, c8, c12, c16 from group P/G and cin in two-level sum-of-products form; no carry ripples between groups.
REQ-014 cout SHALL equal c16.
REQ-015 Behavioural "+" operator SHALL NOT be used in the datapath; explicit p/g logic only.
REQ-016 Boundary: 0xFFFF+0x0000+1 propagates a carry through all 16 bits -> sum 0x0000, cout 1; all-ones inputs with cin=1 -> sum 0xFFFF, cout 1.
REQ-017 Inputs may change every cycle; no handshake; no internal state besides optional output register.

Reset
REQ-018 With CLA_16BIT_REG_OUT_EN defined: rst low SHALL immediately clear sum to 0x0000 and cout to 0, independent of clk, and hold while low.
REQ-019 Reset release SHALL take effect on the next rising clk edge; first registered result appears at that edge.
REQ-020 Reset asserted mid-operation SHALL discard any registered result; no residual output after release until the next edge.
REQ-021 Without the macro, rst has no effect; outputs are purely combinational.

Configuration
REQ-022 Macro CLA_16BIT_REG_OUT_EN: defined -> sum/cout registered on rising clk, latency 1 cycle from input change to output, reset per REQ-018.
REQ-023 Macro undefined -> sum/cout combinational from in_a/in_b/cin, latency 0; clk and rst unused but ports retained.

Verification
REQ-024 in_a=0x0000, in_b=0x0000, cin=0 -> sum=0x0000, cout=0.
REQ-025 in_a=0xFFFF, in_b=0x0001, cin=0 -> sum=0x0000, cout=1 (full carry chain).
REQ-026 in_a=0x00FF, in_b=0x0F01, cin=0 -> sum=0x1000, cout=0 (carry across group boundaries 4/8/12).
REQ-027 in_a=0xFFFF, in_b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-028 20 random vectors (in_a, in_b in 0..65534, cin random), each held 10 cycles then compared against in_a+in_b+cin -> 20/20 match in both macro configurations.
REQ-029 Macro defined: outputs settled at 0x1234+0x0001 -> 0x1235; drive rst low between clock edges -> sum=0x0000, cout=0 immediately; release -> 0x1235 reappears at the next rising edge.
